reg_bus_master: RTL

//  Upstream command master for the register-control slave (sel/wr/addr/wdata, ready, rdata).
//  - Buffers host requests in a FIFO.
//  - Issues them one at a time under the slave's ready rule.
//  - Captures read data exactly one clock after a read is accepted.
//  - Returns it on a valid/ready response port.
//  - Only one slave transaction is outstanding at a time.

---
 rtl/reg_bus_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// reg_bus_master: upstream command master for the register-control slave.
// Host requests are queued in a small FIFO and issued to the slave one at a time.
// Read data is captured one clock after the slave accepts a read, and it is returned
// on a valid/ready response port. Writes produce no response.
// Optional feature: define REG_MST_TIMEOUT_EN to abort an op that waits TIMEOUT_CYCLES
// for m_ready. The op then returns an error response. This applies to reads and writes.
module reg_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          m_sel,
    output logic                          m_wr,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic                          m_ready,
    input  logic [DATA_WIDTH-1:0]         m_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StRdata, StRsp} state_e;

    state_e                  state;

    logic                    fifo_wr    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    // Full blocks a push even when a pop happens in the same cycle.
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready;
    assign pop        = (state == StIdle) && !fifo_empty;

`ifdef REG_MST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]         wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // FIFO storage: needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]    <= req_wr;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of 2.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Transaction FSM: issue, wait for acceptance, capture read data, hold the response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= StIdle;
            m_sel     <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef REG_MST_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        m_addr   <= fifo_addr[rd_ptr];
                        m_wr     <= fifo_wr[rd_ptr];
                        m_wdata  <= fifo_wdata[rd_ptr];
                        m_sel    <= 1'b1;
                        state    <= StReq;
`ifdef REG_MST_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                StReq: begin
                    if (m_sel && m_ready) begin
                        m_sel <= 1'b0;
                        state <= m_wr ? StIdle : StRdata;
                    end
`ifdef REG_MST_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: this stall cycle is the TIMEOUT_CYCLES-th.
                        m_sel     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= StRsp;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StRdata: begin
                    // The slave presents the read data during this single cycle.
                    rsp_data  <= m_rdata;
                    rsp_valid <= 1'b1;
`ifdef REG_MST_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                    state     <= StRsp;
                end
                StRsp: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
